// File: rtl/timefieldedit_pkg.sv
// Shared definitions for the time-field edit engine: digit indices, per-digit limits,
// the packed HH:MM:SS BCD time type and a helper that yields the active limit of a digit.
package timefieldedit_pkg;

    localparam int SO = 0;
    localparam int ST = 1;
    localparam int MO = 2;
    localparam int MT = 3;
    localparam int HO = 4;
    localparam int HT = 5;

    localparam logic [3:0] SO_LIMIT        = 4'd9;
    localparam logic [3:0] ST_LIMIT        = 4'd5;
    localparam logic [3:0] MO_LIMIT        = 4'd9;
    localparam logic [3:0] MT_LIMIT        = 4'd5;
    localparam logic [3:0] HO_LIMIT        = 4'd9;
    localparam logic [3:0] HT_LIMIT        = 4'd2;
    localparam logic [3:0] HO_LIMIT_AT_20H = 4'd3;

    typedef struct packed {
        logic [3:0] ht;
        logic [3:0] ho;
        logic [3:0] mt;
        logic [3:0] mo;
        logic [3:0] st;
        logic [3:0] so;
    } bcd_time_t;

    // Hours-ones shrinks to 0-3 once hours-tens reaches 2 (an out-of-range tens digit counts as 2x).
    function automatic logic [3:0] digit_limit(input logic [2:0] idx, input logic [3:0] ht);
        logic [3:0] lim;
        case (idx)
            3'(SO):  lim = SO_LIMIT;
            3'(ST):  lim = ST_LIMIT;
            3'(MO):  lim = MO_LIMIT;
            3'(MT):  lim = MT_LIMIT;
            3'(HO):  lim = (ht >= HT_LIMIT) ? HO_LIMIT_AT_20H : HO_LIMIT;
            3'(HT):  lim = HT_LIMIT;
            default: lim = 4'd0;
        endcase
        return lim;
    endfunction

endpackage

// File: rtl/timefieldedit_if.sv
// Edit-engine bus: cursor select, edit-mode and button levels, load path and the held time.
interface timefieldedit_if;

    logic [7:0]  sel;
    logic        active;
    logic        up;
    logic        down;
    logic        load;
    logic [23:0] load_time;
    logic [23:0] time_out;
    logic        changed;
    logic        err;

    modport master (
        output sel, active, up, down, load, load_time,
        input  time_out, changed, err
    );

    modport slave (
        input  sel, active, up, down, load, load_time,
        output time_out, changed, err
    );

endinterface

// File: rtl/timefieldedit_bcddigitstep.sv
// Single BCD digit step with wrap-around; values above the limit behave as the limit.
module bcddigitstep (
    input  logic [3:0] digit,
    input  logic [3:0] limit,
    input  logic       dir,
    output logic [3:0] next
);

    always_comb begin
        next = digit;
        if (dir) begin
            next = (digit >= limit) ? 4'd0 : digit + 4'd1;
        end else if (digit == 4'd0) begin
            next = limit;
        end else if (digit > limit) begin
            next = limit - 4'd1;
        end else begin
            next = digit - 4'd1;
        end
    end

endmodule

// File: rtl/timefieldedit.sv
// timefieldedit: set-mode edit engine applying single BCD steps to the cursor-selected digit.
// Define AUTO_REPEAT_EN to add hold-to-repeat stepping timed by REPEAT_DELAY / REPEAT_PERIOD.
module timefieldedit
    import timefieldedit_pkg::*;
#(
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100
) (
    input  logic           clk,
    input  logic           resetn,
    timefieldedit_if.slave bus
);

    bcd_time_t  time_q;
    bcd_time_t  next_time;
    logic       changed_q;
    logic       up_q;
    logic       down_q;
    logic       up_blk;
    logic       down_blk;
    logic       sel_ok;
    logic       step_up;
    logic       step_dn;
    logic       edge_req;
    logic       do_edit;
    logic       dir;
    logic [2:0] idx;
    logic [3:0] cur_digit;
    logic [3:0] cur_limit;
    logic [3:0] new_digit;

    assign sel_ok   = (bus.sel[7:6] == 2'b00) && $onehot(bus.sel[5:0]);
    assign bus.err  = bus.active & ~sel_ok;

    // A button still held across reset stays blocked until it has been seen low once.
    assign step_up  = bus.up & ~up_q & ~up_blk;
    assign step_dn  = bus.down & ~down_q & ~down_blk;
    assign edge_req = step_up ^ step_dn;

`ifdef AUTO_REPEAT_EN
    localparam int REPEAT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W      = $clog2(REPEAT_MAX + 1);
    localparam logic [CNT_W-1:0] DELAY_CNT  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] PERIOD_CNT = CNT_W'(REPEAT_PERIOD);

    logic [CNT_W-1:0] rep_cnt;
    logic             rep_phase;
    logic             held;
    logic             rep_fire;

    // rep_cnt = 0 means idle; otherwise it counts cycles since the last applied step.
    assign held     = bus.active & (bus.up ^ bus.down);
    assign rep_fire = held & (rep_cnt != '0) & (rep_cnt == (rep_phase ? PERIOD_CNT : DELAY_CNT));
    assign do_edit  = bus.active & ~bus.err & ~bus.load & (edge_req | rep_fire);
    assign dir      = edge_req ? step_up : bus.up;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
        end else if (!held || bus.load) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
        end else if (edge_req && do_edit) begin
            rep_cnt   <= CNT_W'(1);
            rep_phase <= 1'b0;
        end else if (rep_fire) begin
            rep_cnt   <= CNT_W'(1);
            rep_phase <= 1'b1;
        end else if (rep_cnt != '0) begin
            rep_cnt   <= rep_cnt + 1'b1;
        end
    end
`else
    assign do_edit = bus.active & ~bus.err & ~bus.load & edge_req;
    assign dir     = step_up;

    if ((REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_repeat_cfg_unused
    end
`endif

    always_comb begin
        idx = 3'd0;
        case (bus.sel[5:0])
            6'b000001: idx = 3'(SO);
            6'b000010: idx = 3'(ST);
            6'b000100: idx = 3'(MO);
            6'b001000: idx = 3'(MT);
            6'b010000: idx = 3'(HO);
            6'b100000: idx = 3'(HT);
            default:   idx = 3'd0;
        endcase
    end

    always_comb begin
        cur_digit = time_q.so;
        case (idx)
            3'(ST):  cur_digit = time_q.st;
            3'(MO):  cur_digit = time_q.mo;
            3'(MT):  cur_digit = time_q.mt;
            3'(HO):  cur_digit = time_q.ho;
            3'(HT):  cur_digit = time_q.ht;
            default: cur_digit = time_q.so;
        endcase
    end

    assign cur_limit = digit_limit(idx, time_q.ht);

    bcddigitstep u_step (
        .digit (cur_digit),
        .limit (cur_limit),
        .dir   (dir),
        .next  (new_digit)
    );

    // Landing hours-tens on 2 pulls an out-of-range hours-ones down to 3 in the same edit.
    always_comb begin
        next_time = time_q;
        case (idx)
            3'(SO): next_time.so = new_digit;
            3'(ST): next_time.st = new_digit;
            3'(MO): next_time.mo = new_digit;
            3'(MT): next_time.mt = new_digit;
            3'(HO): next_time.ho = new_digit;
            3'(HT): begin
                next_time.ht = new_digit;
                if ((new_digit == HT_LIMIT) && (time_q.ho > HO_LIMIT_AT_20H)) begin
                    next_time.ho = HO_LIMIT_AT_20H;
                end
            end
            default: next_time = time_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            time_q    <= '0;
            changed_q <= 1'b0;
            up_q      <= 1'b0;
            down_q    <= 1'b0;
            up_blk    <= 1'b1;
            down_blk  <= 1'b1;
        end else begin
            up_q      <= bus.up;
            down_q    <= bus.down;
            changed_q <= 1'b0;
            if (!bus.up) begin
                up_blk <= 1'b0;
            end
            if (!bus.down) begin
                down_blk <= 1'b0;
            end
            if (bus.load) begin
                time_q <= bus.load_time;
            end else if (do_edit) begin
                time_q    <= next_time;
                changed_q <= 1'b1;
            end
        end
    end

    assign bus.time_out = time_q;
    assign bus.changed  = changed_q;

endmodule

// File: tb/tb_timefieldedit.sv
// Table-driven bench for timefieldedit plus hand-written hold/repeat and mid-hold reset sequences.
module tb_timefieldedit;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    timefieldedit_if bus();

    timefieldedit #(
        .REPEAT_DELAY  (5),
        .REPEAT_PERIOD (3)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic [7:0]  sel;
        logic        active;
        logic        up;
        logic        down;
        logic        load;
        logic [23:0] load_time;
        logic [23:0] exp_time;
        logic        exp_changed;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];
    int   check_count = 0;
    int   pass_count  = 0;

    function automatic vec_t mk(input logic [7:0] sel, input logic active, input logic up,
                                input logic down, input logic load, input logic [23:0] load_time,
                                input logic [23:0] exp_time, input logic exp_changed,
                                input logic exp_err);
        vec_t v;
        v.sel         = sel;
        v.active      = active;
        v.up          = up;
        v.down        = down;
        v.load        = load;
        v.load_time   = load_time;
        v.exp_time    = exp_time;
        v.exp_changed = exp_changed;
        v.exp_err     = exp_err;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        bus.sel       = v.sel;
        bus.active    = v.active;
        bus.up        = v.up;
        bus.down      = v.down;
        bus.load      = v.load;
        bus.load_time = v.load_time;
    endtask

    task automatic checkOutput(input string name, input logic [23:0] exp_time,
                               input logic exp_changed, input logic exp_err);
        check_count++;
        if (bus.time_out === exp_time) pass_count++;
        else $display("[TB] FAIL %s time_out: got %h, want %h", name, bus.time_out, exp_time);
        check_count++;
        if (bus.changed === exp_changed) pass_count++;
        else $display("[TB] FAIL %s changed: got %b, want %b", name, bus.changed, exp_changed);
        check_count++;
        if (bus.err === exp_err) pass_count++;
        else $display("[TB] FAIL %s err: got %b, want %b", name, bus.err, exp_err);
    endtask

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int so_exp;
        logic fires;

        // sel, active, up, down, load, load_time, expected time_out, changed, err
        vecs.push_back(mk(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0,      24'h000000, 1'b0, 1'b0));
        vecs.push_back(mk(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0,      24'h000001, 1'b1, 1'b0));
        vecs.push_back(mk(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0,      24'h000001, 1'b0, 1'b0));
        vecs.push_back(mk(8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 24'h235959, 24'h235959, 1'b0, 1'b0));
        vecs.push_back(mk(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0,      24'h235950, 1'b1, 1'b0));
        vecs.push_back(mk(8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0,      24'h235950, 1'b0, 1'b0));
        vecs.push_back(mk(8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 24'h0,      24'h235940, 1'b1, 1'b0));
        vecs.push_back(mk(8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0,      24'h235940, 1'b0, 1'b0));
        vecs.push_back(mk(8'h02, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0,      24'h235950, 1'b1, 1'b0));
        vecs.push_back(mk(8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0,      24'h235950, 1'b0, 1'b0));
        vecs.push_back(mk(8'h02, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0,      24'h235900, 1'b1, 1'b0));
        vecs.push_back(mk(8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0,      24'h235900, 1'b0, 1'b0));
        vecs.push_back(mk(8'h20, 1'b1, 1'b0, 1'b0, 1'b1, 24'h190000, 24'h190000, 1'b0, 1'b0));
        vecs.push_back(mk(8'h20, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0,      24'h230000, 1'b1, 1'b0));
        vecs.push_back(mk(8'h20, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0,      24'h230000, 1'b0, 1'b0));
        vecs.push_back(mk(8'h20, 1'b1, 1'b0, 1'b0, 1'b1, 24'h090000, 24'h090000, 1'b0, 1'b0));
        vecs.push_back(mk(8'h20, 1'b1, 1'b0, 1'b1, 1'b0, 24'h0,      24'h230000, 1'b1, 1'b0));
        vecs.push_back(mk(8'h20, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0,      24'h230000, 1'b0, 1'b0));
        vecs.push_back(mk(8'h10, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0,      24'h200000, 1'b1, 1'b0));
        vecs.push_back(mk(8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0,      24'h200000, 1'b0, 1'b0));
        vecs.push_back(mk(8'h10, 1'b1, 1'b0, 1'b1, 1'b0, 24'h0,      24'h230000, 1'b1, 1'b0));
        vecs.push_back(mk(8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0,      24'h230000, 1'b0, 1'b0));
        vecs.push_back(mk(8'h40, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0,      24'h230000, 1'b0, 1'b1));
        vecs.push_back(mk(8'h40, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0,      24'h230000, 1'b0, 1'b1));
        vecs.push_back(mk(8'h03, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0,      24'h230000, 1'b0, 1'b1));
        vecs.push_back(mk(8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0,      24'h230000, 1'b0, 1'b1));
        vecs.push_back(mk(8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0,      24'h230000, 1'b0, 1'b0));
        vecs.push_back(mk(8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0,      24'h230000, 1'b0, 1'b0));
        vecs.push_back(mk(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0,      24'h230000, 1'b0, 1'b0));
        vecs.push_back(mk(8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 24'h0,      24'h230000, 1'b0, 1'b0));
        vecs.push_back(mk(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0,      24'h230000, 1'b0, 1'b0));
        vecs.push_back(mk(8'h20, 1'b1, 1'b0, 1'b0, 1'b1, 24'h300000, 24'h300000, 1'b0, 1'b0));
        vecs.push_back(mk(8'h20, 1'b1, 1'b0, 1'b1, 1'b0, 24'h0,      24'h100000, 1'b1, 1'b0));
        vecs.push_back(mk(8'h20, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0,      24'h100000, 1'b0, 1'b0));
        vecs.push_back(mk(8'h20, 1'b1, 1'b0, 1'b0, 1'b1, 24'h300000, 24'h300000, 1'b0, 1'b0));
        vecs.push_back(mk(8'h20, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0,      24'h000000, 1'b1, 1'b0));
        vecs.push_back(mk(8'h20, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0,      24'h000000, 1'b0, 1'b0));
        vecs.push_back(mk(8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 24'h123456, 24'h123456, 1'b0, 1'b0));
        vecs.push_back(mk(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0,      24'h123456, 1'b0, 1'b0));
        vecs.push_back(mk(8'h08, 1'b1, 1'b0, 1'b1, 1'b0, 24'h0,      24'h122456, 1'b1, 1'b0));
        vecs.push_back(mk(8'h08, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0,      24'h122456, 1'b0, 1'b0));
        vecs.push_back(mk(8'h04, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0,      24'h122556, 1'b1, 1'b0));
        vecs.push_back(mk(8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0,      24'h122556, 1'b0, 1'b0));

        resetn = 1'b0;
        applyStimulus(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0, 1'b0));
        repeat (3) @(negedge clk);
        checkOutput("reset", 24'h000000, 1'b0, 1'b0);
        resetn = 1'b1;

        $display("[TB] running %0d table vectors", vecs.size());
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            stepCycle();
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_time, vecs[i].exp_changed,
                        vecs[i].exp_err);
        end

        // Hold up on seconds-ones for 12 cycles; repeat build steps at 0, 5, 8, 11.
        applyStimulus(mk(8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 24'h0, 24'h0, 1'b0, 1'b0));
        stepCycle();
        checkOutput("hold_load", 24'h000000, 1'b0, 1'b0);
        so_exp = 0;
        for (int k = 0; k < 12; k++) begin
`ifdef AUTO_REPEAT_EN
            fires = (k == 0) || (k == 5) || (k == 8) || (k == 11);
`else
            fires = (k == 0);
`endif
            if (fires) so_exp++;
            applyStimulus(mk(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0, 1'b0));
            stepCycle();
            checkOutput($sformatf("hold%0d", k), {20'h0, 4'(so_exp)}, fires, 1'b0);
        end
        applyStimulus(mk(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0, 1'b0));
        stepCycle();
        checkOutput("hold_release", {20'h0, 4'(so_exp)}, 1'b0, 1'b0);

        // Reset while up is held: async clear, then no step until up is released and pressed.
        applyStimulus(mk(8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 24'h0, 24'h0, 1'b0, 1'b0));
        stepCycle();
        checkOutput("rst_load", 24'h000000, 1'b0, 1'b0);
        applyStimulus(mk(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0, 1'b0));
        stepCycle();
        checkOutput("rst_step", 24'h000001, 1'b1, 1'b0);
        stepCycle();
        checkOutput("rst_held", 24'h000001, 1'b0, 1'b0);
        #2 resetn = 1'b0;
        #1 checkOutput("rst_async", 24'h000000, 1'b0, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            stepCycle();
            checkOutput($sformatf("rst_after%0d", k), 24'h000000, 1'b0, 1'b0);
        end
        applyStimulus(mk(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0, 1'b0));
        stepCycle();
        checkOutput("rst_release", 24'h000000, 1'b0, 1'b0);
        applyStimulus(mk(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0, 1'b0));
        stepCycle();
        checkOutput("rst_repress", 24'h000001, 1'b1, 1'b0);
        applyStimulus(mk(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0, 1'b0));
        stepCycle();
        checkOutput("rst_done", 24'h000001, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/timefieldedit.md
# timefieldedit

Edit engine driven by the digit-cursor selector: consumes the cursor's one-hot position select together with up/down button levels and applies single-step BCD edits to the selected digit of an HH:MM:SS time value. Sits between the cursor selector and the alarm/time registers in set mode, and owns the held time value during editing. Enforces per-digit limits and 24-hour validity, so every value it emits is a legal time.

## Interface
- REPEAT_DELAY, 500: cycles a button is held after its first step before auto-repeat begins.
- REPEAT_PERIOD, 100: cycles between auto-repeat steps.
- clk  input  1  single clock; all state updates on the rising edge.
- resetn  input  1  reset, asynchronous and active-low.
- sel  input  8  one-hot digit select from the cursor selector. Bit0 = seconds ones, bit1 = seconds tens, bit2 = minutes ones, bit3 = minutes tens, bit4 = hours ones, bit5 = hours tens. Bits 6–7 are unused.
- active  input  1  edit mode enable; when low, up/down are ignored.
- up  input  1  increment button level, already synchronised and debounced.
- down  input  1  decrement button level, already synchronised and debounced.
- load  input  1  load load_time into the held value.
- load_time  input  24  BCD {HT,HO,MT,MO,ST,SO}, 4 bits each.
- time_out  output  24  held BCD time, same packing as load_time.
- changed  output  1  one-cycle pulse, registered, asserted in the cycle time_out takes a new value from an edit.
- err  output  1  combinational; equals active AND sel[5:0] is not exactly one-hot (this includes any bit 6/7 set).

## Operation
- Reset values: time_out = 24'h000000, changed = 0; internal up_q/down_q = 0; repeat counter = 0.
- Edge detect: step_up = up & ~up_q; step_dn = down & ~down_q. up_q and down_q sample their inputs every cycle.
- Simultaneous step_up and step_dn: no edit, and no changed pulse.
- An edit requires active = 1, err = 0 and exactly one step request; otherwise time_out holds.
- Digit limits:
  - SO and MO: 0–9.
  - ST and MT: 0–5.
  - HT: 0–2.
  - HO: 0–9 when HT < 2, 0–3 when HT = 2.
- Wrap-around: incrementing at the limit gives 0; decrementing at 0 gives the limit.
- Hours coupling: any edit to HT that results in HT = 2 while HO > 3 also forces HO to 3 in the same cycle. This covers both increment 1→2 and decrement 0→2.
- HO limit: when HT = 2, HO wraps at 3 (3→0 on increment, 0→3 on decrement).
- load: has priority over any edit in the same cycle and does not pulse changed.
- Illegal load_time: any field out of range (e.g. HT = 3) is loaded unchanged. Subsequent edits on that digit treat values above the limit as the limit: increment wraps to 0, decrement gives limit − 1.
- Unselected digits never change during an edit.

## Timing
- Edit latency: up rising at cycle n is sampled at the edge ending cycle n. time_out and changed update at that same edge, so they are visible in cycle n+1.
- changed is high for exactly one cycle per applied step.
- Mid-operation reset (resetn low): immediately clears all state, cancels any repeat in progress, and requires a fresh rising edge on the button after reset releases.
- A change of sel while a button is held: the next repeat step applies to the newly selected digit.
- active falling while a button is held: the repeat counter is cleared.

## Configuration
- AUTO_REPEAT_EN defined:
  - While the same single button stays high and active = 1, a counter runs from the initial step.
  - An extra step fires REPEAT_DELAY cycles after the initial step, then every REPEAT_PERIOD cycles.
  - The counter clears on button release, on both buttons being high, or on load.
  - Counter width is $clog2 of max(REPEAT_DELAY, REPEAT_PERIOD) + 1.
- AUTO_REPEAT_EN undefined: exactly one step per rising edge. No counter logic, and REPEAT_* parameters are unused.

## Structure
- Shared package holds:
  - Digit-index constants: SO = 0 … HT = 5.
  - Per-digit limit constants: 9, 5, 9, 5, 9, 2, plus HO_LIMIT_AT_20H = 3.
  - Packed struct typedef for the 6-digit BCD time.
- Sub-module bcddigitstep: combinational; inputs digit[3:0], limit[3:0], dir; output next[3:0] with the wrap rules above. Instantiated once and fed through the sel mux.

## Test plan
- Reset, then sel = 8'h01, active = 1, up pulse, from 00:00:00 → time_out = 24'h000001 one cycle later, changed pulses once.
- load 24'h235959, sel = 8'h01, up → 24'h235950; then sel = 8'h02, down from ST = 5 → ST = 4, giving 24'h235940; then up twice from ST = 4 → 24'h235900 (ST goes 4→5→0).
- load 24'h190000, sel = 8'h20 (HT), up → 24'h230000 (HO clamped 9→3); load 24'h090000, HT down → 24'h230000.
- sel = 8'h40 or 8'h03 with active = 1 → err = 1 and an up pulse leaves time_out unchanged; up and down rising together → no change, changed = 0.
- AUTO_REPEAT_EN with REPEAT_DELAY = 5, REPEAT_PERIOD = 3: hold up on SO from 0 for 12 cycles → steps at cycles 0, 5, 8, 11, ending with SO = 4.
- resetn dropped mid-hold → time_out = 0 asynchronously; no step after release until up falls and rises again.
